d5m_frame_gen: RTL and testbench

D5M_FRAME_GEN -- requirements
Module: d5m_frame_gen

---
 rtl/d5m_frame_gen.sv | 183 ++++++++++++++++++
 tb/tb_d5m_frame_gen.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/d5m_frame_gen.sv
// D5M-style camera frame generator: fvalid/lvalid timing with selectable test patterns.
// Define D5M_FRAME_GEN_LFSR_EN to make pattern 3 an LFSR noise source instead of mid-grey.
module d5m_frame_gen #(
  parameter int IMG_WIDTH  = 64,
  parameter int IMG_HEIGHT = 48,
  parameter int H_BLANK    = 8,
  parameter int V_BLANK    = 16,
  parameter int DATA_WIDTH = 12
) (
  input  logic                  pixclk,
  input  logic                  reset,
  input  logic                  start,
  input  logic                  continuous,
  input  logic [1:0]            pattern_sel,
  output logic                  fvalid,
  output logic                  lvalid,
  output logic [DATA_WIDTH-1:0] rgb,
  output logic [15:0]           x,
  output logic [15:0]           y,
  output logic                  eof,
  output logic                  busy,
  output logic [15:0]           frame_cnt
);

  typedef enum logic [2:0] {IDLE, FV_SETUP, LINE, HBLANK, VBLANK} state_t;

  localparam logic [15:0] X_LAST  = 16'(IMG_WIDTH - 1);
  localparam logic [15:0] Y_LAST  = 16'(IMG_HEIGHT - 1);
  localparam logic [15:0] HB_LAST = 16'(H_BLANK - 1);
  localparam logic [15:0] VB_LAST = 16'(V_BLANK - 1);
  localparam logic [DATA_WIDTH-1:0] MID = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  state_t          state;
  logic [1:0]      pat;
  logic [15:0]     cnt;
  logic [DATA_WIDTH-1:0] p3;

`ifdef D5M_FRAME_GEN_LFSR_EN
  localparam logic [15:0] SEED = 16'hACE1;
  logic [15:0] lfsr;
  assign p3 = lfsr[DATA_WIDTH-1:0];

  // Fibonacci form, taps 16,14,13,11.
  function automatic logic [15:0] lfsr_step(input logic [15:0] s);
    return {s[14:0], s[15] ^ s[13] ^ s[12] ^ s[10]};
  endfunction
`else
  assign p3 = MID;
`endif

  function automatic logic [DATA_WIDTH-1:0] pixel(
    input logic [1:0]            p,
    input logic [DATA_WIDTH-1:0] xv,
    input logic [DATA_WIDTH-1:0] yv,
    input logic [DATA_WIDTH-1:0] noise
  );
    case (p)
      2'd0:    return xv + yv;
      2'd1:    return xv;
      2'd2:    return {DATA_WIDTH{~(xv[0] ^ yv[0])}};
      default: return noise;
    endcase
  endfunction

  // Outputs are loaded together with the state they describe, so rgb/x/y
  // always correspond to the pixel being presented this cycle.
  always_ff @(posedge pixclk) begin
    if (reset) begin
      state     <= IDLE;
      fvalid    <= 1'b0;
      lvalid    <= 1'b0;
      rgb       <= '0;
      x         <= '0;
      y         <= '0;
      eof       <= 1'b0;
      busy      <= 1'b0;
      frame_cnt <= '0;
      pat       <= '0;
      cnt       <= '0;
`ifdef D5M_FRAME_GEN_LFSR_EN
      lfsr      <= SEED;
`endif
    end else begin
      eof <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            state  <= FV_SETUP;
            fvalid <= 1'b1;
            busy   <= 1'b1;
            pat    <= pattern_sel;
            cnt    <= '0;
`ifdef D5M_FRAME_GEN_LFSR_EN
            lfsr   <= SEED;
`endif
          end
        end

        FV_SETUP: begin
          if (cnt == HB_LAST) begin
            state  <= LINE;
            lvalid <= 1'b1;
            cnt    <= '0;
            x      <= '0;
            rgb    <= pixel(pat, '0, '0, p3);
`ifdef D5M_FRAME_GEN_LFSR_EN
            lfsr   <= lfsr_step(lfsr);
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        LINE: begin
          if (x == X_LAST) begin
            lvalid <= 1'b0;
            rgb    <= '0;
            x      <= '0;
            cnt    <= '0;
            if (y == Y_LAST) begin
              state     <= VBLANK;
              fvalid    <= 1'b0;
              y         <= '0;
              eof       <= 1'b1;
              frame_cnt <= frame_cnt + 16'd1;
            end else begin
              state <= HBLANK;
            end
          end else begin
            x   <= x + 16'd1;
            rgb <= pixel(pat, x[DATA_WIDTH-1:0] + 1'b1, y[DATA_WIDTH-1:0], p3);
`ifdef D5M_FRAME_GEN_LFSR_EN
            lfsr <= lfsr_step(lfsr);
`endif
          end
        end

        HBLANK: begin
          if (cnt == HB_LAST) begin
            state  <= LINE;
            lvalid <= 1'b1;
            cnt    <= '0;
            y      <= y + 16'd1;
            rgb    <= pixel(pat, '0, y[DATA_WIDTH-1:0] + 1'b1, p3);
`ifdef D5M_FRAME_GEN_LFSR_EN
            lfsr   <= lfsr_step(lfsr);
`endif
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        VBLANK: begin
          if (cnt == VB_LAST) begin
            cnt <= '0;
            // continuous only matters here, so dropping it mid-frame lets the frame finish.
            if (continuous) begin
              state  <= FV_SETUP;
              fvalid <= 1'b1;
              pat    <= pattern_sel;
`ifdef D5M_FRAME_GEN_LFSR_EN
              lfsr   <= SEED;
`endif
            end else begin
              state <= IDLE;
              busy  <= 1'b0;
            end
          end else begin
            cnt <= cnt + 16'd1;
          end
        end

        default: begin
          state  <= IDLE;
          fvalid <= 1'b0;
          lvalid <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_d5m_frame_gen.sv
// Directed bench for d5m_frame_gen with a 4x2 frame, H_BLANK=2, V_BLANK=3 (15-cycle frames).
// Pattern 3 expectations follow D5M_FRAME_GEN_LFSR_EN when it is defined.
module tb_d5m_frame_gen;
  localparam int W  = 4;
  localparam int H  = 2;
  localparam int HB = 2;
  localparam int VB = 3;
  localparam int DW = 12;

  logic          pixclk = 1'b0;
  logic          reset = 1'b1;
  logic          start = 1'b0;
  logic          continuous = 1'b0;
  logic [1:0]    pattern_sel = 2'd0;
  logic          fvalid, lvalid, eof, busy;
  logic [DW-1:0] rgb;
  logic [15:0]   x, y, frame_cnt;

  int errors = 0;
  int checks = 0;
  int exp_fc = 0;

`ifdef D5M_FRAME_GEN_LFSR_EN
  logic [15:0] lref [8];
`endif

  d5m_frame_gen #(
    .IMG_WIDTH(W), .IMG_HEIGHT(H), .H_BLANK(HB), .V_BLANK(VB), .DATA_WIDTH(DW)
  ) dut (
    .pixclk(pixclk), .reset(reset), .start(start), .continuous(continuous),
    .pattern_sel(pattern_sel), .fvalid(fvalid), .lvalid(lvalid), .rgb(rgb),
    .x(x), .y(y), .eof(eof), .busy(busy), .frame_cnt(frame_cnt)
  );

  always #5 pixclk = ~pixclk;

  task automatic step();
    @(posedge pixclk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  function automatic logic [31:0] exp_rgb(input int pat, input int i, input int xx, input int yy);
    case (pat)
      0: return 32'(xx + yy);
      1: return 32'(xx);
      2: return (((xx ^ yy) & 1) == 0) ? 32'hFFF : 32'h0;
      default: begin
`ifdef D5M_FRAME_GEN_LFSR_EN
        return {16'h0, lref[i]} & 32'hFFF;
`else
        return (i >= 0) ? 32'h800 : 32'h800;
`endif
      end
    endcase
  endfunction

  task automatic check_idle(input string tag);
    chk({tag, ".fvalid"}, fvalid, 0);
    chk({tag, ".lvalid"}, lvalid, 0);
    chk({tag, ".rgb"}, rgb, 0);
    chk({tag, ".x"}, x, 0);
    chk({tag, ".y"}, y, 0);
    chk({tag, ".eof"}, eof, 0);
    chk({tag, ".busy"}, busy, 0);
    chk({tag, ".frame_cnt"}, frame_cnt, exp_fc);
  endtask

  // Checks the 15 cycles of one frame, starting on its first FV_SETUP cycle.
  task automatic check_frame(input int pat, input bit spam);
    for (int k = 0; k < 15; k++) begin
      bit ln;
      int xx, yy;
      ln = (k >= 2 && k <= 5) || (k >= 8 && k <= 11);
      xx = (k >= 8 && k <= 11) ? k - 8 : (k >= 2 && k <= 5) ? k - 2 : 0;
      yy = (k >= 8 && k <= 11) ? 1 : 0;
      chk($sformatf("p%0d.fvalid@%0d", pat, k), fvalid, k < 12);
      chk($sformatf("p%0d.lvalid@%0d", pat, k), lvalid, ln);
      chk($sformatf("p%0d.x@%0d", pat, k), x, xx);
      chk($sformatf("p%0d.y@%0d", pat, k), y, yy);
      chk($sformatf("p%0d.eof@%0d", pat, k), eof, k == 12);
      chk($sformatf("p%0d.busy@%0d", pat, k), busy, 1);
      chk($sformatf("p%0d.rgb@%0d", pat, k), rgb, ln ? exp_rgb(pat, yy * W + xx, xx, yy) : 0);
      chk($sformatf("p%0d.frame_cnt@%0d", pat, k), frame_cnt, (k >= 12) ? exp_fc + 1 : exp_fc);
      if (spam && (k == 3 || k == 13)) start = 1'b1;
      step();
      start = 1'b0;
    end
    exp_fc++;
  endtask

  initial begin
`ifdef D5M_FRAME_GEN_LFSR_EN
    lref[0] = 16'hACE1;
    for (int i = 1; i < 8; i++)
      lref[i] = {lref[i-1][14:0], lref[i-1][15] ^ lref[i-1][13] ^ lref[i-1][12] ^ lref[i-1][10]};
`endif

    // reset state
    reset = 1'b1;
    step();
    step();
    check_idle("reset");
    reset = 1'b0;
    step();
    check_idle("idle");

    // single frame, pattern 0, extra start pulses mid-frame, pattern_sel changed after latch
    pattern_sel = 2'd0;
    continuous  = 1'b0;
    start = 1'b1;
    step();
    start = 1'b0;
    pattern_sel = 2'd3;
    check_frame(0, 1'b1);
    check_idle("after_p0");
    step();
    check_idle("after_p0_hold");

    // single frames for patterns 1..3
    for (int p = 1; p < 4; p++) begin
      pattern_sel = 2'(p);
      start = 1'b1;
      step();
      start = 1'b0;
      pattern_sel = 2'd0;
      check_frame(p, 1'b0);
      check_idle($sformatf("after_p%0d", p));
    end

    // continuous: three back-to-back frames, pattern resampled per frame
    pattern_sel = 2'd0;
    continuous  = 1'b1;
    start = 1'b1;
    step();
    start = 1'b0;
    pattern_sel = 2'd1;
    check_frame(0, 1'b0);
    pattern_sel = 2'd2;
    check_frame(1, 1'b1);
    continuous  = 1'b0;
    pattern_sel = 2'd3;
    check_frame(2, 1'b0);
    check_idle("cont_end");
    step();
    check_idle("cont_end_hold");

    // reset during the second line, with start asserted alongside
    pattern_sel = 2'd1;
    start = 1'b1;
    step();
    start = 1'b0;
    repeat (9) step();
    chk("midframe.lvalid", lvalid, 1);
    chk("midframe.y", y, 1);
    reset = 1'b1;
    start = 1'b1;
    step();
    reset = 1'b0;
    start = 1'b0;
    exp_fc = 0;
    check_idle("midreset");
    for (int i = 0; i < 5; i++) begin
      step();
      check_idle($sformatf("midreset_hold%0d", i));
    end

    // full frame after the aborted one
    pattern_sel = 2'd2;
    start = 1'b1;
    step();
    start = 1'b0;
    check_frame(2, 1'b0);
    check_idle("post_reset_frame");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
